// File: rtl/sdm_pkg.sv
// Shared types for the sdm_demod_ctrl slice: controller state encoding and default sample width.
package sdm_pkg;

  localparam int SDM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } sdm_ctrl_state_t;

  // States in which DSD bits are forwarded to the demodulator.
  function automatic logic sdm_is_feeding(input sdm_ctrl_state_t s);
    return (s == SETTLE) || (s == RUN);
  endfunction

endpackage

// File: rtl/sdm_sync_fifo.sv
// Small first-word-fall-through synchronous FIFO with an occupancy counter.
module sdm_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/sdm_demod_ctrl.sv
// Sequencer for one sdm_demodulator: flush, settle-discard, run into an output FIFO, drain.
// Optional macro SDM_CTRL_STATS_EN adds sample_cnt/drop_cnt statistics outputs.
module sdm_demod_ctrl
  import sdm_pkg::*;
#(
  parameter int DATA_W       = SDM_DATA_W,
  parameter int FIFO_DEPTH   = 8,
  parameter int FLUSH_CYCLES = 4,
  parameter int SETTLE_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [SETTLE_W-1:0] settle_cnt,
  input  logic                bit_tick,
  input  logic                bit_in,
  output logic                demod_rst_n,
  output logic                demod_valid_in,
  output logic                demod_din,
  input  logic                demod_valid_out,
  input  logic [DATA_W-1:0]   demod_dout,
  output logic                pcm_valid,
  input  logic                pcm_ready,
  output logic [DATA_W-1:0]   pcm_data,
  output logic                busy,
  output logic [2:0]          state_o,
  output logic                overflow
`ifdef SDM_CTRL_STATS_EN
  ,
  output logic [31:0]         sample_cnt,
  output logic [15:0]         drop_cnt
`endif
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  sdm_ctrl_state_t     state_q, state_d;
  logic [FLUSH_W-1:0]  flush_q, flush_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                overflow_q, overflow_d;
  logic                valid_in_q, valid_in_d;
  logic                din_q, din_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                pop;
  logic                push_req;
  logic                push_ok;
  logic                drop;
  logic                start_ok;

  assign pop      = ~fifo_empty & pcm_ready;
  assign push_req = (state_q == RUN) & demod_valid_out;
  assign push_ok  = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;
  assign start_ok = (state_q == IDLE) & start & ~stop;

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    settle_d   = settle_q;
    overflow_d = overflow_q | drop;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d    = FLUSH;
          flush_d    = '0;
          settle_d   = settle_cnt;
          overflow_d = 1'b0;
        end
      end
      FLUSH: begin
        if (stop)                       state_d = DRAIN;
        else if (flush_q == FLUSH_LAST) state_d = (settle_q == '0) ? RUN : SETTLE;
        else                            flush_d = flush_q + 1'b1;
      end
      SETTLE: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (demod_valid_out) begin
          // The sample that brings the count to zero is discarded as well.
          settle_d = settle_q - 1'b1;
          if (settle_q == SETTLE_W'(1)) state_d = RUN;
        end
      end
      RUN: begin
        if (stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty || (pop && fifo_count == CNT_W'(1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Gate on the next state so no strobe leaks out after leaving SETTLE/RUN.
    valid_in_d = bit_tick & sdm_is_feeding(state_d);
    din_d      = valid_in_d ? bit_in : din_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flush_q    <= '0;
      settle_q   <= '0;
      overflow_q <= 1'b0;
      valid_in_q <= 1'b0;
      din_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      settle_q   <= settle_d;
      overflow_q <= overflow_d;
      valid_in_q <= valid_in_d;
      din_q      <= din_d;
    end
  end

  sdm_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pcm_ready),
    .wdata (demod_dout),
    .head  (pcm_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign demod_rst_n    = (state_q != IDLE) && (state_q != FLUSH);
  assign demod_valid_in = valid_in_q;
  assign demod_din      = din_q;
  assign pcm_valid      = ~fifo_empty;
  assign busy           = (state_q != IDLE);
  assign state_o        = state_q;
  assign overflow       = overflow_q;

`ifdef SDM_CTRL_STATS_EN
  logic [31:0] sample_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (push_ok) sample_cnt_q <= sample_cnt_q + 32'd1;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sdm_demod_ctrl.sv
// Self-checking bench for sdm_demod_ctrl: vector table, corner sequences, random run vs queue model.
module tb_sdm_demod_ctrl;
  import sdm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  settle_cnt = 8'd0;
  logic        bit_tick = 1'b0;
  logic        bit_in = 1'b0;
  logic        demod_rst_n;
  logic        demod_valid_in;
  logic        demod_din;
  logic        demod_valid_out = 1'b0;
  logic [15:0] demod_dout = 16'd0;
  logic        pcm_valid;
  logic        pcm_ready = 1'b0;
  logic [15:0] pcm_data;
  logic        busy;
  logic [2:0]  state_o;
  logic        overflow;
`ifdef SDM_CTRL_STATS_EN
  logic [31:0] sample_cnt;
  logic [15:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdm_demod_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stop            (stop),
    .settle_cnt      (settle_cnt),
    .bit_tick        (bit_tick),
    .bit_in          (bit_in),
    .demod_rst_n     (demod_rst_n),
    .demod_valid_in  (demod_valid_in),
    .demod_din       (demod_din),
    .demod_valid_out (demod_valid_out),
    .demod_dout      (demod_dout),
    .pcm_valid       (pcm_valid),
    .pcm_ready       (pcm_ready),
    .pcm_data        (pcm_data),
    .busy            (busy),
    .state_o         (state_o),
    .overflow        (overflow)
`ifdef SDM_CTRL_STATS_EN
    ,
    .sample_cnt      (sample_cnt),
    .drop_cnt        (drop_cnt)
`endif
  );

  typedef struct {
    logic            start;
    logic            stop;
    logic [7:0]      settle;
    logic            dvo;
    logic [15:0]     dout;
    logic            rdy;
    sdm_ctrl_state_t st;
    logic            rstn;
    logic            pv;
    logic [15:0]     pd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit s, input bit p, input int set, input bit v, input int d,
                              input bit r, input sdm_ctrl_state_t st, input bit rn, input bit pv,
                              input int pd);
    vec_t x;
    x.start = s;  x.stop = p;  x.settle = 8'(set); x.dvo = v; x.dout = 16'(d);
    x.rdy = r;    x.st = st;   x.rstn = rn;        x.pv = pv; x.pd = 16'(pd);
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic begin_run();
    start = 1'b1; settle_cnt = 8'd0;
    step();
    start = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int q[$];
    bit exp_ovf;
    int drops, pushes;
    bit exp_vin, exp_din, pop, seen_idle;

    // ---------------- reset state ----------------
    repeat (2) step();
    chk("rst demod_rst_n", 32'(demod_rst_n), 32'd0);
    chk("rst demod_valid_in", 32'(demod_valid_in), 32'd0);
    chk("rst demod_din", 32'(demod_din), 32'd0);
    chk("rst pcm_valid", 32'(pcm_valid), 32'd0);
    chk("rst pcm_data", 32'(pcm_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst state", 32'(state_o), 32'(IDLE));
    chk("rst overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();

    // ---------------- table: settle=3, samples 10..15, drain, start+stop ----------------
    vecs.push_back(mk(1, 0, 3, 0, 0,  0, FLUSH,  0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0,  0, FLUSH,  0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0,  0, FLUSH,  0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0,  0, FLUSH,  0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0,  0, SETTLE, 1, 0, 0));
    vecs.push_back(mk(0, 0, 3, 1, 10, 0, SETTLE, 1, 0, 0));
    vecs.push_back(mk(0, 0, 3, 1, 11, 0, SETTLE, 1, 0, 0));
    vecs.push_back(mk(0, 0, 3, 1, 12, 0, RUN,    1, 0, 0));
    vecs.push_back(mk(0, 0, 3, 1, 13, 0, RUN,    1, 1, 13));
    vecs.push_back(mk(0, 0, 3, 1, 14, 0, RUN,    1, 1, 13));
    vecs.push_back(mk(0, 0, 3, 1, 15, 0, RUN,    1, 1, 13));
    vecs.push_back(mk(0, 0, 3, 0, 0,  1, RUN,    1, 1, 14));
    vecs.push_back(mk(0, 0, 3, 0, 0,  1, RUN,    1, 1, 15));
    vecs.push_back(mk(0, 0, 3, 0, 0,  1, RUN,    1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0,  1, DRAIN,  1, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0,  0, IDLE,   0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 0, 0,  0, IDLE,   0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0,  0, IDLE,   0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; stop = vecs[i].stop; settle_cnt = vecs[i].settle;
      demod_valid_out = vecs[i].dvo; demod_dout = vecs[i].dout; pcm_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].st != IDLE));
      chk($sformatf("vec%0d demod_rst_n", i), 32'(demod_rst_n), 32'(vecs[i].rstn));
      chk($sformatf("vec%0d pcm_valid", i), 32'(pcm_valid), 32'(vecs[i].pv));
      chk($sformatf("vec%0d pcm_data", i), 32'(pcm_data), 32'(vecs[i].pd));
    end
    start = 1'b0; stop = 1'b0; demod_valid_out = 1'b0; pcm_ready = 1'b0;

    // ---------------- settle=0 latency, then reset mid-RUN with 3 queued ----------------
    begin_run();
    chk("settle0 straight to RUN", 32'(state_o), 32'(RUN));
    demod_valid_out = 1'b1; demod_dout = 16'h00A1;
    step();
    chk("first sample pcm_valid", 32'(pcm_valid), 32'd1);
    chk("first sample pcm_data", 32'(pcm_data), 32'h00A1);
    demod_dout = 16'h00A2; step();
    demod_dout = 16'h00A3; step();
    demod_valid_out = 1'b0;
    rst = 1'b1;
    step();
    chk("midrun rst pcm_valid", 32'(pcm_valid), 32'd0);
    chk("midrun rst state", 32'(state_o), 32'(IDLE));
    chk("midrun rst demod_rst_n", 32'(demod_rst_n), 32'd0);
    rst = 1'b0;
    step();

    // ---------------- overflow: 10 pushes into depth 8 ----------------
    begin_run();
    for (int i = 0; i < 10; i++) begin
      demod_valid_out = 1'b1; demod_dout = 16'(100 + i);
      step();
    end
    demod_valid_out = 1'b0;
    chk("ovf overflow", 32'(overflow), 32'd1);
`ifdef SDM_CTRL_STATS_EN
    chk("ovf drop_cnt", 32'(drop_cnt), 32'd2);
    chk("ovf sample_cnt", sample_cnt, 32'd8);
`endif
    pcm_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf drain %0d", i), 32'(pcm_data), 32'(100 + i));
      step();
    end
    chk("ovf drained empty", 32'(pcm_valid), 32'd0);
    pcm_ready = 1'b0;
    stop = 1'b1; step(); stop = 1'b0; step();
    chk("ovf back to IDLE", 32'(state_o), 32'(IDLE));

    // ---------------- full FIFO with simultaneous push and pop ----------------
    begin_run();
    chk("new start clears overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      demod_valid_out = 1'b1; demod_dout = 16'(16'h200 + i);
      step();
    end
    pcm_ready = 1'b1; demod_dout = 16'h208;
    step();
    demod_valid_out = 1'b0;
    chk("full push+pop overflow", 32'(overflow), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("full drain %0d", i), 32'(pcm_data), 32'(16'h200 + i));
      step();
    end
    chk("full drain empty", 32'(pcm_valid), 32'd0);
    pcm_ready = 1'b0;

    // ---------------- stop in RUN with 5 queued ----------------
    bit_tick = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      demod_valid_out = 1'b1; demod_dout = 16'(16'h300 + i);
      step();
    end
    demod_valid_out = 1'b0;
    chk("run demod_valid_in", 32'(demod_valid_in), 32'd1);
    chk("run demod_din", 32'(demod_din), 32'd1);
    stop = 1'b1; pcm_ready = 1'b1;
    step();
    stop = 1'b0;
    chk("stop -> DRAIN", 32'(state_o), 32'(DRAIN));
    chk("drain demod_valid_in", 32'(demod_valid_in), 32'd0);
    chk("drain demod_rst_n", 32'(demod_rst_n), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      demod_valid_out = 1'b1; demod_dout = 16'hDEAD;
      step();
      chk($sformatf("drain step %0d state", k), 32'(state_o), 32'((k == 4) ? IDLE : DRAIN));
    end
    demod_valid_out = 1'b0; bit_tick = 1'b0; pcm_ready = 1'b0;
    chk("drain done pcm_valid", 32'(pcm_valid), 32'd0);

    // ---------------- randomized RUN traffic vs queue model ----------------
    begin_run();
    exp_ovf = 1'b0; drops = 0; pushes = 0; exp_vin = 1'b0; exp_din = demod_din;
    for (int c = 0; c < 400; c++) begin
      demod_valid_out = 1'($urandom_range(0, 1));
      demod_dout      = 16'($urandom);
      pcm_ready       = ($urandom_range(0, 99) < (((c / 100) % 2 == 1) ? 80 : 25)) ? 1'b1 : 1'b0;
      bit_tick        = 1'($urandom_range(0, 1));
      bit_in          = 1'($urandom_range(0, 1));
      chk($sformatf("rnd%0d pcm_valid", c), 32'(pcm_valid), 32'(q.size() != 0));
      chk($sformatf("rnd%0d pcm_data", c), 32'(pcm_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk($sformatf("rnd%0d overflow", c), 32'(overflow), 32'(exp_ovf));
      chk($sformatf("rnd%0d valid_in", c), 32'(demod_valid_in), 32'(exp_vin));
      chk($sformatf("rnd%0d din", c), 32'(demod_din), 32'(exp_din));
      pop = (q.size() != 0) && pcm_ready;
      if (demod_valid_out) begin
        if (q.size() < 8 || pop) pushes++;
        else begin drops++; exp_ovf = 1'b1; end
      end
      if (pop) void'(q.pop_front());
      if (demod_valid_out && (q.size() < 8) && !(drops > 0 && exp_ovf && q.size() == 8)) begin
        if (q.size() < 8) q.push_back(int'(demod_dout));
      end
      exp_vin = bit_tick;
      if (bit_tick) exp_din = bit_in;
      step();
    end
    demod_valid_out = 1'b0; bit_tick = 1'b0;
`ifdef SDM_CTRL_STATS_EN
    chk("rnd sample_cnt", sample_cnt, 32'(pushes));
    chk("rnd drop_cnt", 32'(drop_cnt), 32'(drops));
`endif

    // ---------------- final drain ----------------
    stop = 1'b1; pcm_ready = 1'b1;
    step();
    stop = 1'b0;
    seen_idle = 1'b0;
    for (int i = 0; i < 20 && !seen_idle; i++) begin
      if (state_o == 3'(IDLE)) seen_idle = 1'b1;
      else step();
    end
    chk("final drain reaches IDLE", 32'(state_o), 32'(IDLE));
    chk("final pcm_valid", 32'(pcm_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
